// File: rtl/verinject_injection_controller_pkg.sv
// Shared constants for the fault-injection controller: idle broadcast value,
// FSM state encodings and a saturating increment helper.
package verinject_injection_controller_pkg;

  // No injector range ever covers this value, so it means "nothing injected".
  localparam logic [31:0] VERINJECT_IDLE_STATE = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_INJECT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/verinject_down_counter.sv
// Loadable down counter with synchronous clear; it stops at zero and never underflows.
module verinject_down_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/verinject_injection_controller.sv
// Sequencer for the per-register fault injectors: accepts one command, waits
// <delay> cycles, then broadcasts <target> for max(hold,1) cycles.
module verinject_injection_controller
  import verinject_injection_controller_pkg::*;
#(
  parameter int unsigned MAX_BITS   = 1024,
  parameter logic [31:0] IDLE_STATE = VERINJECT_IDLE_STATE,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_target,
  input  logic [31:0]       cfg_delay,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              abort,
  output logic [31:0]       verinject__injector_state,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       inject_count
);

  if (IDLE_STATE < MAX_BITS) begin : g_bad_idle
    $error("IDLE_STATE must lie outside the injectable range 0..MAX_BITS-1");
  end

  logic [1:0]        state;
  logic [31:0]       target_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_load;
  logic [31:0]       delay_count;
  logic [HOLD_W-1:0] hold_count;
  logic              delay_zero;
  logic              hold_zero;
  logic              accept;
  logic              in_range;
  logic              enter_inject;

  assign cfg_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign accept       = cfg_valid && cfg_ready && !abort;
  assign in_range     = (cfg_target < MAX_BITS);
  assign enter_inject = (state == ST_ARMED) && delay_zero && !abort;
  // A hold of zero is treated as one cycle, so the counter starts one below.
  assign hold_load    = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);

  verinject_down_counter #(.W(32)) u_delay_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (abort),
    .load       (accept && in_range),
    .load_value (cfg_delay),
    .dec        (state == ST_ARMED),
    .count      (delay_count),
    .zero       (delay_zero)
  );

  verinject_down_counter #(.W(HOLD_W)) u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (abort),
    .load       (enter_inject),
    .load_value (hold_load),
    .dec        (state == ST_INJECT),
    .count      (hold_count),
    .zero       (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= ST_IDLE;
      verinject__injector_state <= IDLE_STATE;
      done                      <= 1'b0;
      err                       <= 1'b0;
      inject_count              <= '0;
      target_q                  <= '0;
      hold_q                    <= '0;
    end else if (abort) begin
      state                     <= ST_IDLE;
      verinject__injector_state <= IDLE_STATE;
      done                      <= 1'b0;
      err                       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            target_q <= cfg_target;
            hold_q   <= cfg_hold;
            if (in_range) begin
              state <= ST_ARMED;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (delay_zero) begin
            state                     <= ST_INJECT;
            verinject__injector_state <= target_q;
            inject_count              <= sat_inc(inject_count);
          end
        end
        ST_INJECT: begin
          if (hold_zero) begin
            state                     <= ST_DONE;
            verinject__injector_state <= IDLE_STATE;
            done                      <= 1'b1;
            err                       <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
